// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front panel: FSM encoding, default
// timing parameters and the saturating time-setting step.
package microwave_pkg;

    localparam int TIN_W           = 4;
    localparam int BEEP_CYCLES_DEF = 8;
    localparam int ARM_TIMEOUT_DEF = 4;

    localparam logic [TIN_W-1:0] TIN_MAX = {TIN_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Up and down together cancel; both directions saturate instead of wrapping.
    function automatic logic [TIN_W-1:0] step_set(input logic [TIN_W-1:0] cur,
                                                  input logic              up,
                                                  input logic              dn);
        logic [TIN_W-1:0] nxt;
        nxt = cur;
        if (up && !dn && cur != TIN_MAX) begin
            nxt = cur + 1'b1;
        end else if (dn && !up && cur != '0) begin
            nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/microwave_panel_key_edge.sv
// Registered rising-edge detector for one panel key; a key already held when
// reset releases is absorbed on the first clock and never reported as a press.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_edge
);

    logic r_cur;
    logic r_prev;
    logic r_primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur    <= 1'b0;
            r_prev   <= 1'b0;
            r_primed <= 1'b0;
        end else if (!r_primed) begin
            r_cur    <= i_key;
            r_prev   <= i_key;
            r_primed <= 1'b1;
        end else begin
            r_prev <= r_cur;
            r_cur  <= i_key;
        end
    end

    assign o_edge = r_cur & ~r_prev;

endmodule

// File: rtl/microwave_panel.sv
// Microwave front panel: debounced-edge key handling, time setting, and the
// IDLE/ARM/RUN/DONE sequencer that drives the oven timer core.
module microwave_panel
    import microwave_pkg::*;
#(
    parameter int BEEP_CYCLES = BEEP_CYCLES_DEF,
    parameter int ARM_TIMEOUT = ARM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_up,
    input  logic             key_dn,
    input  logic             key_start,
    input  logic             key_stop,
    input  logic             door,
    input  logic             p,
    output logic [TIN_W-1:0] tin,
    output logic             r,
    output logic             clr,
    output logic             beep,
    output logic             busy,
    output logic [1:0]       o_state
);

    localparam int ARM_CW  = $clog2(ARM_TIMEOUT + 1);
    localparam int BEEP_CW = $clog2(BEEP_CYCLES + 1);
    localparam logic [ARM_CW-1:0]  ARM_LAST  = ARM_CW'(ARM_TIMEOUT - 1);
    localparam logic [BEEP_CW-1:0] BEEP_LAST = BEEP_CW'(BEEP_CYCLES - 1);

    logic w_up;
    logic w_dn;
    logic w_start;
    logic w_stop;
    logic w_any_key;
    logic w_cancel;

    state_t             r_state;
    logic [TIN_W-1:0]   r_set;
    logic               r_run;
    logic               r_clr;
    logic               r_beep;
    logic               r_busy;
    logic [ARM_CW-1:0]  r_arm_cnt;
    logic [BEEP_CW-1:0] r_beep_cnt;

    key_edge u_edge_up    (.clk(clk), .rst(rst), .i_key(key_up),    .o_edge(w_up));
    key_edge u_edge_dn    (.clk(clk), .rst(rst), .i_key(key_dn),    .o_edge(w_dn));
    key_edge u_edge_start (.clk(clk), .rst(rst), .i_key(key_start), .o_edge(w_start));
    key_edge u_edge_stop  (.clk(clk), .rst(rst), .i_key(key_stop),  .o_edge(w_stop));

    assign w_any_key = w_up | w_dn | w_start | w_stop;
    assign w_cancel  = w_stop | door;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_set      <= '0;
            r_run      <= 1'b0;
            r_clr      <= 1'b0;
            r_beep     <= 1'b0;
            r_busy     <= 1'b0;
            r_arm_cnt  <= '0;
            r_beep_cnt <= '0;
        end else begin
            r_clr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_set <= step_set(r_set, w_up, w_dn);
                    if (w_start && r_set != '0 && !door && !w_stop) begin
                        r_state    <= ST_ARM;
                        r_run      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_arm_cnt  <= '0;
                        r_beep_cnt <= '0;
                    end
                end
                ST_ARM: begin
                    // Cancel outranks p, and the timeout shares the cancel exit.
                    if (w_cancel || (!p && r_arm_cnt == ARM_LAST)) begin
                        r_state    <= ST_IDLE;
                        r_run      <= 1'b0;
                        r_busy     <= 1'b0;
                        r_clr      <= 1'b1;
                        r_arm_cnt  <= '0;
                        r_beep_cnt <= '0;
                    end else if (p) begin
                        r_state    <= ST_RUN;
                        r_arm_cnt  <= '0;
                        r_beep_cnt <= '0;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_cancel) begin
                        r_state    <= ST_IDLE;
                        r_run      <= 1'b0;
                        r_busy     <= 1'b0;
                        r_clr      <= 1'b1;
                        r_arm_cnt  <= '0;
                        r_beep_cnt <= '0;
                    end else if (!p) begin
                        r_state    <= ST_DONE;
                        r_run      <= 1'b0;
                        r_busy     <= 1'b0;
                        r_beep     <= 1'b1;
                        r_arm_cnt  <= '0;
                        r_beep_cnt <= '0;
                    end
                end
                ST_DONE: begin
                    // Any press silences the alarm without performing its action.
                    if (w_any_key || r_beep_cnt == BEEP_LAST) begin
                        r_state    <= ST_IDLE;
                        r_beep     <= 1'b0;
                        r_arm_cnt  <= '0;
                        r_beep_cnt <= '0;
                    end else begin
                        r_beep_cnt <= r_beep_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_run      <= 1'b0;
                    r_busy     <= 1'b0;
                    r_beep     <= 1'b0;
                    r_arm_cnt  <= '0;
                    r_beep_cnt <= '0;
                end
            endcase
        end
    end

    assign tin     = r_set;
    assign r       = r_run;
    assign clr     = r_clr;
    assign beep    = r_beep;
    assign busy    = r_busy;
    assign o_state = r_state;

endmodule

// File: tb/tb_microwave_panel.sv
// Directed bench for microwave_panel: a per-cycle vector table plus
// hand-written sequences for saturation, alarm interrupt and mid-run reset.
module tb_microwave_panel;
    import microwave_pkg::*;

    logic       clk;
    logic       rst;
    logic       key_up;
    logic       key_dn;
    logic       key_start;
    logic       key_stop;
    logic       door;
    logic       p;
    logic [3:0] tin;
    logic       r;
    logic       clr;
    logic       beep;
    logic       busy;
    logic [1:0] o_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Output bundle: {tin[3:0], r, clr, beep, busy, state[1:0]}
    logic [9:0] exp_q[$];

    typedef struct {
        logic       up, dn, st, sp, dr, pp;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    microwave_panel dut (
        .clk(clk), .rst(rst), .key_up(key_up), .key_dn(key_dn),
        .key_start(key_start), .key_stop(key_stop), .door(door), .p(p),
        .tin(tin), .r(r), .clr(clr), .beep(beep), .busy(busy), .o_state(o_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_up();
        key_up = 1'b1; tick(); key_up = 1'b0; tick();
    endtask

    task automatic press_dn();
        key_dn = 1'b1; tick(); key_dn = 1'b0; tick();
    endtask

    task automatic press_start();
        key_start = 1'b1; tick(); key_start = 1'b0; tick();
    endtask

    function automatic logic [9:0] mk(input int t, input bit rr, input bit cc,
                                      input bit bb, input bit bu, input state_t s);
        logic [3:0] t4;
        t4 = 4'(t);
        return {t4, rr, cc, bb, bu, 2'(s)};
    endfunction

    task automatic add(input bit up, input bit dn, input bit st, input bit sp,
                       input bit dr, input bit pp, input logic [9:0] exp);
        vec_t v;
        v.up = up; v.dn = dn; v.st = st; v.sp = sp; v.dr = dr; v.pp = pp;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = {tin, r, clr, beep, busy, o_state};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got tin=%0d r=%b clr=%b beep=%b busy=%b state=%0d, expected tin=%0d r=%b clr=%b beep=%b busy=%b state=%0d",
                     name, got[9:6], got[5], got[4], got[3], got[2], got[1:0],
                     exp[9:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic check_tin(input string name, input logic [3:0] exp);
        n_tests++;
        if (tin !== exp) begin
            n_fail++;
            $display("FAIL %s: got tin=%0d, expected tin=%0d", name, tin, exp);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        rst = 1'b1;
        key_up = 0; key_dn = 0; key_start = 0; key_stop = 0; door = 0; p = 0;

        // Cook cycle with tin=3
        add(1,0,0,0,0,0, mk(0,0,0,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(1,0,0,0,0,ST_IDLE));
        add(1,0,0,0,0,0, mk(1,0,0,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(2,0,0,0,0,ST_IDLE));
        add(1,0,0,0,0,0, mk(2,0,0,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        add(0,0,1,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(3,1,0,0,1,ST_ARM));
        add(0,0,0,0,0,1, mk(3,1,0,0,1,ST_RUN));
        add(0,0,0,0,0,1, mk(3,1,0,0,1,ST_RUN));
        for (int i = 0; i < 8; i++)
            add(0,0,0,0,0,0, mk(3,0,0,1,0,ST_DONE));
        add(0,0,0,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        // Door opens during RUN
        add(0,0,1,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(3,1,0,0,1,ST_ARM));
        add(0,0,0,0,0,1, mk(3,1,0,0,1,ST_RUN));
        add(0,0,0,0,1,1, mk(3,0,1,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        // ARM timeout without p
        add(0,0,1,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        for (int i = 0; i < 4; i++)
            add(0,0,0,0,0,0, mk(3,1,0,0,1,ST_ARM));
        add(0,0,0,0,0,0, mk(3,0,1,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        // Start and stop together in IDLE
        add(0,0,1,1,0,0, mk(3,0,0,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        // Stop key during RUN beats p
        add(0,0,1,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(3,1,0,0,1,ST_ARM));
        add(0,0,0,0,0,1, mk(3,1,0,0,1,ST_RUN));
        add(0,0,0,1,0,1, mk(3,1,0,0,1,ST_RUN));
        add(0,0,0,0,0,1, mk(3,0,1,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        // Start with door open is ignored
        add(0,0,1,0,1,0, mk(3,0,0,0,0,ST_IDLE));
        add(0,0,0,0,1,0, mk(3,0,0,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        // Up+dn together cancel, then one dn
        add(1,1,0,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        add(0,1,0,0,0,0, mk(3,0,0,0,0,ST_IDLE));
        add(0,0,0,0,0,0, mk(2,0,0,0,0,ST_IDLE));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", mk(0,0,0,0,0,ST_IDLE));
        rst = 1'b0;
        tick(); tick();

        foreach (vecs[i]) exp_q.push_back(vecs[i].exp);
        foreach (vecs[i]) begin
            key_up = vecs[i].up; key_dn = vecs[i].dn; key_start = vecs[i].st;
            key_stop = vecs[i].sp; door = vecs[i].dr; p = vecs[i].pp;
            tick();
            check($sformatf("vec%0d", i), exp_q.pop_front());
        end
        key_up = 0; key_dn = 0; key_start = 0; key_stop = 0; door = 0; p = 0;

        // Saturation at 15 and 0; start with zero setting is ignored
        repeat (20) press_up();
        check_tin("sat_high", 4'd15);
        repeat (20) press_dn();
        check_tin("sat_low", 4'd0);
        press_start();
        tick(); tick();
        check("start_zero_ignored", mk(0,0,0,0,0,ST_IDLE));

        // Key press during DONE ends the alarm without acting
        press_up(); press_up();
        press_start();
        check("done_arm", mk(2,1,0,0,1,ST_ARM));
        p = 1'b1; tick();
        check("done_run", mk(2,1,0,0,1,ST_RUN));
        p = 1'b0; tick();
        check("done_enter", mk(2,0,0,1,0,ST_DONE));
        key_up = 1'b1; tick();
        check("done_cycle2", mk(2,0,0,1,0,ST_DONE));
        key_up = 1'b0; tick();
        check("done_key_exit", mk(2,0,0,0,0,ST_IDLE));

        // Reset mid-RUN with key_start held
        press_start();
        p = 1'b1; tick();
        check("rst_run", mk(2,1,0,0,1,ST_RUN));
        key_start = 1'b1; tick();
        #2 rst = 1'b1;
        p = 1'b0;
        #1 check("rst_async", mk(0,0,0,0,0,ST_IDLE));
        @(negedge clk) rst = 1'b0;
        tick(); tick();
        press_up();
        tick(); tick();
        check("rst_held_start", mk(1,0,0,0,0,ST_IDLE));
        key_start = 1'b0; tick();
        key_start = 1'b1; tick();
        key_start = 1'b0; tick();
        check("rst_restart", mk(1,1,0,0,1,ST_ARM));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
